// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into little-endian words, writes them into
// instruction memory and releases the core only after a checksum-valid image.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] cnt_full;
  logic        xfer;

  assign s_ready_o   = (state_q == StHdr0) || (state_q == StHdr1) ||
                       (state_q == StData) || (state_q == StCsum);
  assign wr_en_o     = (state_q == StWrite);
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign core_hold_o = (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign error_o     = (state_q == StErr);

  assign xfer     = s_valid_i && s_ready_o;
  assign cnt_full = {s_data_i, cnt_q[7:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    word_d     = word_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StHdr0;
      end
      StHdr0: begin
        if (xfer) begin
          cnt_d[7:0] = s_data_i;
          state_d    = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          cnt_d      = cnt_full;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          if (32'(cnt_full) > DEPTH_WORDS) state_d = StErr;
          else if (cnt_full == 16'd0)     state_d = StCsum;
          else                            state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = s_data_i;
          csum_d     = csum_q ^ s_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch the write now so it is presented in the very next cycle.
            wr_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            wr_data_d = {s_data_i, word_q[23:0]};
            state_d   = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == cnt_q) state_d = StCsum;
        else                             state_d = StData;
      end
      StCsum: begin
        if (xfer) state_d = (s_data_i == csum_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (start_i) state_d = StHdr0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench: a frame-position model predicts every memory write (with its cycle)
// and the final outcome; a negedge compare process checks the DUT against it.
module tb_imem_loader;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset, start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, wr_en, core_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(s_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .core_hold_o(core_hold), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;
  wr_t exp_q[$];
  wr_t log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: frame position decides meaning of each accepted byte.
  int          m_pos, m_n, m_result;  // result: 0 pending, 1 done, 2 error
  logic [7:0]  m_acc;
  logic [31:0] m_word;

  function automatic void model_reset();
    m_pos = 0; m_n = 0; m_result = 0; m_acc = '0; m_word = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int unsigned c);
    int idx;
    wr_t w;
    if (m_pos == 0) m_n = int'(b);
    else if (m_pos == 1) begin
      m_n += int'(b) * 256;
      if (m_n > int'(DEPTH)) m_result = 2;
    end else if (m_pos < 2 + 4 * m_n) begin
      idx = m_pos - 2;
      m_word[8*(idx%4) +: 8] = b;
      m_acc ^= b;
      if (idx % 4 == 3) begin
        w.addr = BASE + 32'(4 * (idx / 4));
        w.data = m_word;
        w.cyc  = c + 1;
        exp_q.push_back(w);
      end
    end else m_result = (b == m_acc) ? 1 : 2;
    m_pos++;
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      if (wr_en) begin
        wr_t w;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h at cycle %0d, none due", wr_addr,
                   wr_data, cyc);
        end else begin
          check("wr_addr", wr_addr, exp_q[0].addr);
          check("wr_data", wr_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        w.addr = wr_addr; w.data = wr_data; w.cyc = cyc;
        log_q.push_back(w);
        check("ready_in_write", {31'd0, s_ready}, 32'd0);
      end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missed_write: got no wr_en want addr %h at cycle %0d", exp_q[0].addr, cyc);
        void'(exp_q.pop_front());
      end
      check("hold_vs_done", {31'd0, core_hold}, {31'd0, ~done});
      check("done_and_error", {31'd0, done & error}, 32'd0);
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1; s_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  // Send bytes until the model says the frame ended, or stop after stop_after bytes.
  task automatic send_frame(input logic [7:0] bytes[$], input int gap_pct, input int stop_after);
    int budget;
    model_reset();
    for (int i = 0; i < bytes.size(); i++) begin
      if (m_result != 0 || i == stop_after) break;
      while ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        s_valid = 1'b0;
        start   = ($urandom_range(3) == 0);  // must be ignored mid-frame
      end
      @(negedge clk);
      start = 1'b0; s_valid = 1'b1; s_data = bytes[i];
      #1;
      budget = 40;
      while (!s_ready) begin
        @(negedge clk); #1;
        budget--;
        if (budget == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ready_timeout: got s_ready=0 want 1 for byte %0d", i);
          s_valid = 1'b0;
          return;
        end
      end
      model_byte(bytes[i], cyc);
    end
    @(negedge clk);
    s_valid = 1'b0; start = 1'b0;
  endtask

  task automatic check_outcome(input string tag);
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_done"}, {31'd0, done}, {31'd0, m_result == 1});
    check({tag, "_error"}, {31'd0, error}, {31'd0, m_result == 2});
    check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, m_result != 1});
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic build_random(output logic [7:0] f[$], input int n, input bit bad_csum);
    logic [7:0] acc, b;
    acc = '0;
    f.delete();
    f.push_back(n[7:0]); f.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      acc ^= b;
      f.push_back(b);
    end
    f.push_back(bad_csum ? ~acc : acc);
  endtask

  initial begin
    logic [7:0] f1[$], f[$];
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    f1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h90};
    repeat (3) @(negedge clk);
    check("rst_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    reset = 1'b0; chk_en = 1'b1;

    // Reference frame, hand-computed writes.
    log_q.delete();
    do_start(); send_frame(f1, 0, -1); check_outcome("c1");
    check("c1_nwr", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("c1_a0", log_q[0].addr, 32'h0);
      check("c1_d0", log_q[0].data, 32'h0000_0513);
      check("c1_a1", log_q[1].addr, 32'h4);
      check("c1_d1", log_q[1].data, 32'h0010_0593);
    end

    // Bad checksum.
    f = f1; f[10] = 8'h91; log_q.delete();
    do_start(); send_frame(f, 0, -1); check_outcome("c2");
    check("c2_nwr", 32'(log_q.size()), 32'd2);
    check("c2_error", {31'd0, error}, 32'd1);

    // Oversize header: 257 words.
    f = '{8'h01, 8'h01}; log_q.delete();
    do_start(); send_frame(f, 0, -1); check_outcome("c3");
    check("c3_nwr", 32'(log_q.size()), 32'd0);

    // Gappy stream.
    log_q.delete();
    do_start(); send_frame(f1, 40, -1); check_outcome("c4");
    check("c4_nwr", 32'(log_q.size()), 32'd2);

    // Reset after 6 payload bytes, then a fresh load.
    log_q.delete();
    do_start(); send_frame(f1, 0, 8);
    @(negedge clk); reset = 1'b1; exp_q.delete();
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    check("c5_nwr", 32'(log_q.size()), 32'd1);
    check("c5_hold", {31'd0, core_hold}, 32'd1);
    check("c5_done", {31'd0, done}, 32'd0);
    do_start(); send_frame(f1, 0, -1); check_outcome("c5b");

    // Empty image.
    f = '{8'h00, 8'h00, 8'h00}; log_q.delete();
    do_start(); send_frame(f, 0, -1); check_outcome("c6");
    check("c6_nwr", 32'(log_q.size()), 32'd0);
    check("c6_done", {31'd0, done}, 32'd1);

    // Exactly DEPTH words is accepted.
    build_random(f, 256, 1'b0); log_q.delete();
    do_start(); send_frame(f, 0, -1); check_outcome("full");
    check("full_nwr", 32'(log_q.size()), 32'd256);

    // Large oversize count exercises the upper header byte.
    f = '{8'h00, 8'h80}; do_start(); send_frame(f, 0, -1); check_outcome("big");

    for (int t = 0; t < 16; t++) begin
      build_random(f, int'($urandom_range(0, 6)), $urandom_range(3) == 0);
      do_start(); send_frame(f, int'($urandom_range(0, 60)), -1); check_outcome("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
